// File: rtl/maxnet_pkg.sv
// -----------------------------------------------------------------------------
// maxnet_pkg
// Shared definitions for the Maxnet iteration controller:
//   - default parameter constants
//   - FSM state type (IDLE..DONE)
//   - popcount / one-hot index helpers used by maxnet_winner_sel
// Optional feature macro used by the controller: MAXNET_TIMEOUT_EN
// -----------------------------------------------------------------------------
package maxnet_pkg;

  localparam int unsigned N_NEURONS_DEF   = 4;
  localparam int unsigned MAX_ITER_DEF    = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 256;

  // Helper functions operate on a fixed-width vector; callers zero-extend.
  localparam int unsigned VEC_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_KICK   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_EVAL   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  function automatic int unsigned popcount(input logic [VEC_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < VEC_MAX_W; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Index of the highest set bit; only meaningful when v is one-hot.
  function automatic int unsigned onehot_idx(input logic [VEC_MAX_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < VEC_MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/maxnet_iter_ctrl_if.sv
// -----------------------------------------------------------------------------
// maxnet_iter_ctrl_if
// Bundles the controller's handshake, PLU strobes and result signals.
//   master : run requester / PLU side (drives start, plu_done, alive)
//   slave  : maxnet_iter_ctrl (drives strobes, status and results)
// Signals:
//   start, plu_done, alive[N_NEURONS]            requester/PLU -> controller
//   start_plu, we_a_reg, eps_reg_we, we_prim,
//   rst, mux_sel, busy, finish                    controller strobes/status
//   iter_cnt[ITER_W], winner_idx[IDX_W],
//   winner_valid, no_winner, limit_hit, timeout   controller results
// -----------------------------------------------------------------------------
interface maxnet_iter_ctrl_if #(
  parameter int unsigned N_NEURONS = maxnet_pkg::N_NEURONS_DEF,
  parameter int unsigned MAX_ITER  = maxnet_pkg::MAX_ITER_DEF
);
  localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);
  localparam int unsigned IDX_W  = $clog2(N_NEURONS);

  logic                 start;
  logic                 plu_done;
  logic [N_NEURONS-1:0] alive;
  logic                 start_plu;
  logic                 we_a_reg;
  logic                 eps_reg_we;
  logic                 we_prim;
  logic                 rst;
  logic                 mux_sel;
  logic                 busy;
  logic                 finish;
  logic [ITER_W-1:0]    iter_cnt;
  logic [IDX_W-1:0]     winner_idx;
  logic                 winner_valid;
  logic                 no_winner;
  logic                 limit_hit;
  logic                 timeout;

  modport master (
    output start, plu_done, alive,
    input  start_plu, we_a_reg, eps_reg_we, we_prim, rst, mux_sel, busy, finish,
    input  iter_cnt, winner_idx, winner_valid, no_winner, limit_hit, timeout
  );

  modport slave (
    input  start, plu_done, alive,
    output start_plu, we_a_reg, eps_reg_we, we_prim, rst, mux_sel, busy, finish,
    output iter_cnt, winner_idx, winner_valid, no_winner, limit_hit, timeout
  );

endinterface

// File: rtl/maxnet_winner_sel.sv
// -----------------------------------------------------------------------------
// maxnet_winner_sel
// Combinational survivor classification of the alive vector.
// Ports:
//   i_alive  in  N_NEURONS  per-lane activation>0 flags
//   o_none   out 1          no lane alive
//   o_one    out 1          exactly one lane alive
//   o_many   out 1          more than one lane alive
//   o_idx    out IDX_W      index of the surviving lane (valid with o_one)
// -----------------------------------------------------------------------------
module maxnet_winner_sel
  import maxnet_pkg::*;
#(
  parameter int unsigned N_NEURONS = N_NEURONS_DEF,
  localparam int unsigned IDX_W    = $clog2(N_NEURONS)
) (
  input  logic [N_NEURONS-1:0] i_alive,
  output logic                 o_none,
  output logic                 o_one,
  output logic                 o_many,
  output logic [IDX_W-1:0]     o_idx
);

  logic [VEC_MAX_W-1:0] w_vec;
  int unsigned          w_pc;

  always_comb begin
    w_vec                 = '0;
    w_vec[N_NEURONS-1:0]  = i_alive;
    w_pc                  = popcount(w_vec);
    o_none                = (w_pc == 0);
    o_one                 = (w_pc == 1);
    o_many                = (w_pc > 1);
    o_idx                 = IDX_W'(onehot_idx(w_vec));
  end

endmodule

// File: rtl/maxnet_iter_ctrl.sv
// -----------------------------------------------------------------------------
// maxnet_iter_ctrl
// Maxnet sequencing FSM: loads weights/epsilon/primary input, then repeats
// the PLU inhibition step until one lane survives, all lanes die, or
// MAX_ITER steps have run. All outputs are registered and Moore-decoded.
// Ports:
//   clk      in  rising-edge clock
//   rst_cnt  in  synchronous active-high reset (valid in any state)
//   bus      maxnet_iter_ctrl_if.slave: start/plu_done/alive in; PLU strobes,
//            busy/finish, iter_cnt, winner_idx and status flags out
// Optional feature: define MAXNET_TIMEOUT_EN to add a PLU watchdog
// (parameter TIMEOUT_CYC); otherwise timeout stays 0 and WAIT holds forever.
// -----------------------------------------------------------------------------
module maxnet_iter_ctrl
  import maxnet_pkg::*;
#(
  parameter int unsigned N_NEURONS   = N_NEURONS_DEF,
  parameter int unsigned MAX_ITER    = MAX_ITER_DEF
`ifdef MAXNET_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input logic               clk,
  input logic               rst_cnt,
  maxnet_iter_ctrl_if.slave bus
);

  localparam int unsigned       ITER_W    = $clog2(MAX_ITER + 1);
  localparam int unsigned       IDX_W     = $clog2(N_NEURONS);
  localparam logic [ITER_W-1:0] LAST_STEP = ITER_W'(MAX_ITER - 1);

  state_t              r_state;
  logic                r_start_plu;
  logic                r_we_a_reg;
  logic                r_eps_reg_we;
  logic                r_we_prim;
  logic                r_dp_rst;
  logic                r_mux_sel;
  logic                r_busy;
  logic                r_finish;
  logic [ITER_W-1:0]   r_iter_cnt;
  logic [IDX_W-1:0]    r_winner_idx;
  logic                r_winner_valid;
  logic                r_no_winner;
  logic                r_limit_hit;
  logic                r_timeout;

  logic                w_none;
  logic                w_one;
  logic                w_many;
  logic [IDX_W-1:0]    w_idx;

`ifdef MAXNET_TIMEOUT_EN
  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] r_wdog;
`endif

  maxnet_winner_sel #(.N_NEURONS(N_NEURONS)) u_winner_sel (
    .i_alive (bus.alive),
    .o_none  (w_none),
    .o_one   (w_one),
    .o_many  (w_many),
    .o_idx   (w_idx)
  );

  // Strobes are assigned on the transition into their state so that each
  // output register mirrors the current state without a decode stage.
  always_ff @(posedge clk) begin
    if (rst_cnt) begin
      r_state        <= ST_IDLE;
      r_start_plu    <= 1'b0;
      r_we_a_reg     <= 1'b0;
      r_eps_reg_we   <= 1'b0;
      r_we_prim      <= 1'b0;
      r_dp_rst       <= 1'b0;
      r_mux_sel      <= 1'b0;
      r_busy         <= 1'b0;
      r_finish       <= 1'b0;
      r_iter_cnt     <= '0;
      r_winner_idx   <= '0;
      r_winner_valid <= 1'b0;
      r_no_winner    <= 1'b0;
      r_limit_hit    <= 1'b0;
      r_timeout      <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
      r_wdog         <= '0;
`endif
    end else begin
      r_start_plu  <= 1'b0;
      r_we_a_reg   <= 1'b0;
      r_eps_reg_we <= 1'b0;
      r_we_prim    <= 1'b0;
      r_dp_rst     <= 1'b0;
      r_mux_sel    <= 1'b0;
      r_finish     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state        <= ST_LOAD;
            r_we_a_reg     <= 1'b1;
            r_eps_reg_we   <= 1'b1;
            r_we_prim      <= 1'b1;
            r_dp_rst       <= 1'b1;
            r_mux_sel      <= 1'b1;
            r_busy         <= 1'b1;
            r_iter_cnt     <= '0;
            r_winner_idx   <= '0;
            r_winner_valid <= 1'b0;
            r_no_winner    <= 1'b0;
            r_limit_hit    <= 1'b0;
            r_timeout      <= 1'b0;
          end
        end

        ST_LOAD: begin
          r_state     <= ST_KICK;
          r_start_plu <= 1'b1;
`ifdef MAXNET_TIMEOUT_EN
          r_wdog      <= '0;
`endif
        end

        ST_KICK: r_state <= ST_WAIT;

        ST_WAIT: begin
          if (bus.plu_done) begin
            r_state <= ST_EVAL;
`ifdef MAXNET_TIMEOUT_EN
          end else if (r_wdog == WD_LAST) begin
            r_state   <= ST_DONE;
            r_finish  <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
`endif
          end
        end

        ST_EVAL: begin
          // Reporting k for step k means counting the evaluated step here.
          if (w_one || w_none || r_iter_cnt == LAST_STEP) begin
            r_state        <= ST_DONE;
            r_finish       <= 1'b1;
            r_iter_cnt     <= r_iter_cnt + ITER_W'(1);
            r_winner_valid <= w_one;
            r_no_winner    <= w_none;
            r_limit_hit    <= w_many;
            if (w_one) r_winner_idx <= w_idx;
          end else begin
            r_state    <= ST_UPDATE;
            r_we_a_reg <= 1'b1;
          end
        end

        ST_UPDATE: begin
          r_state     <= ST_KICK;
          r_start_plu <= 1'b1;
          r_iter_cnt  <= r_iter_cnt + ITER_W'(1);
`ifdef MAXNET_TIMEOUT_EN
          r_wdog      <= '0;
`endif
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_plu    = r_start_plu;
  assign bus.we_a_reg     = r_we_a_reg;
  assign bus.eps_reg_we   = r_eps_reg_we;
  assign bus.we_prim      = r_we_prim;
  assign bus.rst          = r_dp_rst;
  assign bus.mux_sel      = r_mux_sel;
  assign bus.busy         = r_busy;
  assign bus.finish       = r_finish;
  assign bus.iter_cnt     = r_iter_cnt;
  assign bus.winner_idx   = r_winner_idx;
  assign bus.winner_valid = r_winner_valid;
  assign bus.no_winner    = r_no_winner;
  assign bus.limit_hit    = r_limit_hit;
  assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_maxnet_iter_ctrl
// Self-checking bench for maxnet_iter_ctrl (N=4, MAX_ITER=16; TIMEOUT_CYC=8
// when MAXNET_TIMEOUT_EN is defined). Each run's outcome is predicted from
// the per-step alive vectors; cycle timing is checked against the documented
// latencies.
// -----------------------------------------------------------------------------
module tb_maxnet_iter_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned MI = 16;
`ifdef MAXNET_TIMEOUT_EN
  localparam int unsigned TO = 8;
`endif

  logic clk = 1'b0;
  logic rst_cnt;
  always #5 clk = ~clk;

  maxnet_iter_ctrl_if #(.N_NEURONS(N), .MAX_ITER(MI)) bus ();

  maxnet_iter_ctrl #(
    .N_NEURONS(N),
    .MAX_ITER (MI)
`ifdef MAXNET_TIMEOUT_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk     (clk),
    .rst_cnt (rst_cnt),
    .bus     (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned kick_cnt = 0;

  logic [N-1:0] vecs[MI];
  int unsigned  exp_steps;
  int unsigned  exp_idx;
  logic         exp_wv, exp_nw, exp_lh;

  always @(negedge clk) if (bus.start_plu === 1'b1) kick_cnt++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {bus.we_a_reg, bus.we_prim, bus.eps_reg_we, bus.mux_sel, bus.rst};
  endfunction

  function automatic logic [3:0] flags();
    return {bus.winner_valid, bus.no_winner, bus.limit_hit, bus.timeout};
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({bus.start_plu, bus.busy, bus.finish, strobes(), bus.iter_cnt,
                bus.winner_idx, flags()});
  endfunction

  // Outcome of a run from the step rules: stop on 1 or 0 survivors, else
  // stop after MI steps with the limit flag.
  task automatic predict();
    int unsigned pc;
    exp_steps = 0; exp_idx = 0;
    exp_wv = 1'b0; exp_nw = 1'b0; exp_lh = 1'b0;
    for (int unsigned k = 0; k < MI; k++) begin
      exp_steps = k + 1;
      pc = $countones(vecs[k]);
      if (pc == 1) begin
        exp_wv = 1'b1;
        for (int unsigned b = 0; b < N; b++) if (vecs[k][b]) exp_idx = b;
        break;
      end
      if (pc == 0) begin
        exp_nw = 1'b1;
        break;
      end
    end
    if (!exp_wv && !exp_nw) exp_lh = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at an IDLE negedge.
  task automatic do_run(input int unsigned gap_max, input bit noisy, output int unsigned kicks);
    int unsigned base, gap;
    predict();
    base = kick_cnt;
    bus.start = 1'b1;
    @(negedge clk);                                   // LOAD
    bus.start = 1'b0;
    check_val("load_strobes", {bus.start_plu, strobes()}, 6'b011111);
    check_val("load_busy", bus.busy, 1);
    check_val("load_clr", {bus.iter_cnt, bus.winner_idx, flags()}, 0);
    for (int unsigned k = 0; k < exp_steps; k++) begin
      @(negedge clk);                                 // KICK
      check_val("kick_pulse", {bus.start_plu, strobes()}, 6'b100000);
      check_val("kick_iter", bus.iter_cnt, k);
      if (noisy && $urandom_range(1, 0) == 1) begin
        bus.plu_done = 1'b1;                          // must be ignored in KICK
        bus.alive    = N'($urandom);
      end
      @(negedge clk);                                 // WAIT
      bus.plu_done = 1'b0;
      check_val("wait_quiet", {bus.start_plu, bus.finish, strobes()}, 0);
      gap = $urandom_range(gap_max, 0);
      for (int unsigned g = 0; g < gap; g++) begin
        if (noisy) bus.start = 1'($urandom_range(1, 0));
        @(negedge clk);
        check_val("wait_hold", {bus.start_plu, bus.finish, bus.busy}, 3'b001);
      end
      bus.start    = 1'b0;
      bus.alive    = vecs[k];
      bus.plu_done = 1'b1;
      @(negedge clk);                                 // EVAL
      bus.plu_done = 1'b0;
      check_val("eval_quiet", {bus.start_plu, bus.finish, strobes()}, 0);
      @(negedge clk);                                 // DONE or UPDATE
      if (k == exp_steps - 1) begin
        check_val("done_finish", {bus.finish, bus.busy, bus.start_plu}, 3'b110);
        check_val("done_flags", flags(), {exp_wv, exp_nw, exp_lh, 1'b0});
        check_val("done_iter", bus.iter_cnt, exp_steps);
        check_val("done_idx", bus.winner_idx, exp_idx);
      end else begin
        check_val("update_strobes", {bus.start_plu, bus.finish, strobes()}, 7'b0010000);
      end
    end
    @(negedge clk);                                   // IDLE
    check_val("idle_status", {bus.finish, bus.busy, bus.start_plu}, 0);
    check_val("idle_hold", {bus.iter_cnt, bus.winner_idx, flags()},
              {exp_steps[4:0], exp_idx[1:0], exp_wv, exp_nw, exp_lh, 1'b0});
    kicks = kick_cnt - base;
    check_val("kick_count", kicks, exp_steps);
    // plu_done while idle must leave everything untouched
    bus.plu_done = 1'b1;
    @(negedge clk);
    bus.plu_done = 1'b0;
    check_val("idle_plu_done", {bus.start_plu, bus.busy, strobes(), flags()},
              {7'b0, exp_wv, exp_nw, exp_lh, 1'b0});
  endtask

  initial begin
    int unsigned kicks;
    int unsigned seen;
    logic [3:0]  to_flags;

    bus.start = 1'b0; bus.plu_done = 1'b0; bus.alive = '0;
    rst_cnt = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_outs", all_outs(), 0);
    rst_cnt = 1'b0;
    @(negedge clk);
    check_val("reset_idle", all_outs(), 0);

    // Winner at step 3, lane 2
    for (int unsigned k = 0; k < MI; k++) vecs[k] = 4'b1111;
    vecs[0] = 4'b0110; vecs[1] = 4'b0110; vecs[2] = 4'b0100;
    do_run(0, 1'b0, kicks);
    check_val("dir_win_valid", bus.winner_valid, 1);
    check_val("dir_win_idx", bus.winner_idx, 2);
    check_val("dir_win_iter", bus.iter_cnt, 3);

    // Extinction on the first step
    vecs[0] = 4'b0000;
    do_run(0, 1'b0, kicks);
    check_val("dir_ext_flag", bus.no_winner, 1);
    check_val("dir_ext_iter", bus.iter_cnt, 1);

    // All lanes alive for the whole run
    for (int unsigned k = 0; k < MI; k++) vecs[k] = 4'b1111;
    do_run(1, 1'b0, kicks);
    check_val("dir_lim_flag", bus.limit_hit, 1);
    check_val("dir_lim_iter", bus.iter_cnt, 16);
    check_val("dir_lim_kicks", kicks, 16);

    // Reset in the middle of WAIT
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_cnt = 1'b1;
    @(negedge clk);
    check_val("midrun_reset", all_outs(), 0);
    rst_cnt = 1'b0;
    @(negedge clk);
    check_val("midrun_idle", all_outs(), 0);
    vecs[0] = 4'b1010; vecs[1] = 4'b0001;
    do_run(2, 1'b1, kicks);
    check_val("post_reset_idx", bus.winner_idx, 0);

    // PLU never answers
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);                                   // KICK
    seen = 0; to_flags = '0;
`ifdef MAXNET_TIMEOUT_EN
    for (int unsigned c = 1; c <= TO + 4; c++) begin
      @(negedge clk);
      if (bus.finish === 1'b1 && seen == 0) begin
        seen = c;
        to_flags = flags();
      end
    end
    check_val("timeout_cycle", seen, TO + 1);
    check_val("timeout_flags", to_flags, 4'b0001);
    check_val("timeout_idle", {bus.busy, flags()}, 5'b00001);
`else
    for (int unsigned c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.finish === 1'b1) seen++;
      to_flags = to_flags | flags();
    end
    check_val("wait_forever_finish", seen, 0);
    check_val("wait_forever_busy", {bus.busy, to_flags}, 5'b10000);
`endif
    rst_cnt = 1'b1;
    @(negedge clk);
    rst_cnt = 1'b0;
    @(negedge clk);
    check_val("timeout_reset", all_outs(), 0);

    // Randomized runs
    for (int unsigned r = 0; r < 40; r++) begin
      for (int unsigned k = 0; k < MI; k++) vecs[k] = N'($urandom);
      if (r % 8 == 7) for (int unsigned k = 0; k < MI; k++) vecs[k] = 4'b1011;
      do_run(3, 1'b1, kicks);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
